// File: rtl/sram_controller_param.sv
// Host-to-async-SRAM bridge: splits DW-bit host transfers into 16-bit SRAM beats.
// Optional build macro SRAM_CTRL_POSTED_WRITE_EN moves the write ack to the first beat.
module sram_controller_param #(
    parameter int DW      = 32,
    parameter int AW      = 18,
    parameter int RD_WAIT = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_ADDR,
    input  logic [DW-1:0] i_WDATA,
    input  logic [DW/8-1:0] i_BMASK,
    input  logic          i_WREN,
    input  logic          i_RDEN,
    output logic          o_READY,
    output logic [DW-1:0] o_RDATA,
    output logic          o_ACK,
    output logic [AW-1:0] SRAM_ADDR,
    inout  wire  [15:0]   SRAM_DQ,
    output logic          SRAM_CE_N,
    output logic          SRAM_WE_N,
    output logic          SRAM_OE_N,
    output logic          SRAM_LB_N,
    output logic          SRAM_UB_N
);

    localparam int BEATS = DW / 16;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WCW   = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [WCW-1:0] WAIT_TOP  = WCW'(RD_WAIT - 1);
    localparam logic [AW-1:0]  LOW_MASK  = AW'(BEATS - 1);

`ifdef SRAM_CTRL_POSTED_WRITE_EN
    localparam bit POSTED_WRITE = 1'b1;
`else
    localparam bit POSTED_WRITE = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RACK} state_t;

    state_t            state_q, state_d;
    logic [BCW-1:0]    beat_q, beat_d;
    logic [WCW-1:0]    wait_q, wait_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   mask_q, mask_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              last_beat;
    logic              accept;
    logic              dq_oe;
    logic [15:0]       dq_out;

    assign last_beat = (beat_q == LAST_BEAT);
    assign accept    = o_READY && (i_WREN ^ i_RDEN);
    assign o_RDATA   = rdata_q;
    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
        end
    end

    // Wait counter runs down to zero; zero marks the sample cycle of the beat.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE, S_RACK: state_d = S_IDLE;
            S_WRITE: begin
                if (last_beat) state_d = S_IDLE;
                else           beat_d  = beat_q + 1'b1;
            end
            S_READ: begin
                if (wait_q == '0) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (beat_q == BCW'(k)) rdata_d[16*k +: 16] = SRAM_DQ;
                    end
                    if (last_beat) begin
                        state_d = S_RACK;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        wait_d = WAIT_TOP;
                    end
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
        endcase
        if (accept) begin
            state_d = i_WREN ? S_WRITE : S_READ;
            beat_d  = '0;
            wait_d  = WAIT_TOP;
            addr_d  = i_ADDR & ~LOW_MASK;
            wdata_d = i_WDATA;
            mask_d  = i_BMASK;
        end
    end

    always_comb begin
        o_READY   = 1'b0;
        o_ACK     = 1'b0;
        SRAM_ADDR = '0;
        SRAM_CE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        unique case (state_q)
            S_IDLE: o_READY = 1'b1;
            S_WRITE: begin
                SRAM_CE_N = 1'b0;
                SRAM_WE_N = 1'b0;
                SRAM_ADDR = addr_q | AW'(beat_q);
                dq_oe     = 1'b1;
                for (int k = 0; k < BEATS; k++) begin
                    if (beat_q == BCW'(k)) begin
                        dq_out                 = wdata_q[16*k +: 16];
                        {SRAM_UB_N, SRAM_LB_N} = ~mask_q[2*k +: 2];
                    end
                end
                o_READY = last_beat;
                o_ACK   = POSTED_WRITE ? (beat_q == '0) : last_beat;
            end
            S_READ: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                SRAM_ADDR = addr_q | AW'(beat_q);
            end
            S_RACK: begin
                SRAM_CE_N = 1'b0;
                o_READY   = 1'b1;
                o_ACK     = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_controller_param.sv
// Scoreboard bench for sram_controller_param with a behavioural 16-bit SRAM model.
module tb_sram_controller_param;
    localparam int DW      = 32;
    localparam int AW      = 18;
    localparam int RD_WAIT = 2;
    localparam int BEATS   = DW / 16;
`ifdef SRAM_CTRL_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif
    localparam int WR_LAT = POSTED ? 1 : BEATS;
    localparam int RD_LAT = BEATS * RD_WAIT + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_init;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] bmask;
    logic            wren, rden;
    wire             ready, ack;
    wire  [DW-1:0]   rdata;
    wire  [AW-1:0]   sram_addr;
    wire  [15:0]     sram_dq;
    wire             ce_n, we_n, oe_n, lb_n, ub_n;

    typedef struct {
        logic          is_rd;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t        q[$];
    logic [15:0] sram [0:1023];
    logic [15:0] refm [0:1023];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    sram_controller_param #(.DW(DW), .AW(AW), .RD_WAIT(RD_WAIT)) dut (
        .i_clk(clk), .i_reset(rst), .i_ADDR(addr), .i_WDATA(wdata), .i_BMASK(bmask),
        .i_WREN(wren), .i_RDEN(rden), .o_READY(ready), .o_RDATA(rdata), .o_ACK(ack),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n),
        .SRAM_OE_N(oe_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pat(int i);
        return 16'((i * 291) ^ 23130);
    endfunction

    assign sram_dq = (!oe_n && !ce_n && we_n) ? sram[sram_addr[9:0]] : 16'bz;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) sram[i] <= pat(i);
        end else if (!ce_n && !we_n) begin
            if (!lb_n) sram[sram_addr[9:0]][7:0]  <= sram_dq[7:0];
            if (!ub_n) sram[sram_addr[9:0]][15:8] <= sram_dq[15:8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && ack) begin
            if (q.size() == 0) begin
                chk("spurious_ack", 64'(ack), 64'd0);
            end else begin
                e = q.pop_front();
                chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                if (e.is_rd) chk("rdata", 64'(rdata), 64'(e.data));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW/8-1:0] m);
        exp_t          e;
        logic [AW-1:0] base;
        logic [9:0]    idx;
        logic [DW-1:0] rd;
        wait_ready();
        addr = a; wdata = d; bmask = m; wren = wr; rden = !wr;
        base = a & ~AW'(BEATS - 1);
        rd = '0;
        for (int k = 0; k < BEATS; k++) begin
            idx = 10'(base | AW'(k));
            if (wr) begin
                for (int b = 0; b < 2; b++)
                    if (m[2*k+b]) refm[idx][8*b +: 8] = d[16*k+8*b +: 8];
            end else begin
                rd[16*k +: 16] = refm[idx];
            end
        end
        e.is_rd = !wr;
        e.data  = rd;
        e.cyc   = cyc + (wr ? WR_LAT : RD_LAT);
        q.push_back(e);
        @(negedge clk);
        wren = 1'b0; rden = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_reset_pins(input string tag);
        chk({tag, "_rdata"}, 64'(rdata), 64'd0);
        chk({tag, "_ack"}, 64'(ack), 64'd0);
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        chk({tag, "_addr"}, 64'(sram_addr), 64'd0);
        chk({tag, "_ctl"}, 64'({ce_n, we_n, oe_n, ub_n, lb_n}), 64'b11111);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        wren = 1'b0; rden = 1'b0; addr = '0; wdata = '0; bmask = '0;
        for (int i = 0; i < 1024; i++) refm[i] = pat(i);
        repeat (3) @(negedge clk);
        chk_reset_pins("reset");
        rst = 1'b0; mem_init = 1'b0;
        @(negedge clk);
        chk_reset_pins("idle");

        // Two-beat write with address alignment
        issue(1'b1, 18'h00101, 32'hDEADBEEF, 4'hF);
        chk("w1_addr", 64'(sram_addr), 64'h100);
        chk("w1_dq", 64'(sram_dq), 64'hBEEF);
        chk("w1_we", 64'({ce_n, we_n, oe_n}), 64'b001);
        chk("w1_ack", 64'(ack), 64'(POSTED));
        chk("w1_ready", 64'(ready), 64'd0);
        @(negedge clk);
        chk("w2_addr", 64'(sram_addr), 64'h101);
        chk("w2_dq", 64'(sram_dq), 64'hDEAD);
        chk("w2_bytes", 64'({ub_n, lb_n}), 64'b00);
        chk("w2_ready", 64'(ready), 64'd1);
        chk("w2_ack", 64'(ack), 64'(!POSTED));

        // Back-to-back write then read of the same location
        issue(1'b1, 18'h00100, 32'hABCD1234, 4'hF);
        issue(1'b0, 18'h00100, '0, '0);
        for (int i = 0; i < 4; i++) begin
            chk("rd_ctl", 64'({ce_n, we_n, oe_n}), 64'b010);
            chk("rd_addr", 64'(sram_addr), 64'(18'h100 + i / 2));
            chk("rd_ack", 64'(ack), 64'd0);
            @(negedge clk);
        end
        chk("rack_ack", 64'(ack), 64'd1);
        chk("rack_data", 64'(rdata), 64'hABCD1234);
        chk("rack_ready", 64'(ready), 64'd1);

        // Partial mask: beat 0 fully masked, beat 1 low byte only
        issue(1'b1, 18'h00200, 32'h55667788, 4'h4);
        chk("m0_bytes", 64'({ub_n, lb_n}), 64'b11);
        chk("m0_we", 64'(we_n), 64'd0);
        @(negedge clk);
        chk("m1_bytes", 64'({ub_n, lb_n}), 64'b10);
        chk("rdata_hold", 64'(rdata), 64'hABCD1234);
        issue(1'b0, 18'h00200, '0, '0);
        drain();

        // Conflicting request is ignored
        wren = 1'b1; rden = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("both_ce", 64'(ce_n), 64'd1);
            chk("both_ack", 64'(ack), 64'd0);
            chk("both_ready", 64'(ready), 64'd1);
        end
        wren = 1'b0; rden = 1'b0;

        // Random traffic over a small window
        for (int i = 0; i < 24; i++) begin
            issue(1'($urandom_range(0, 1)), 18'h300 + 18'($urandom_range(0, 63)),
                  DW'({$urandom, $urandom}), (DW/8)'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 8; i++) issue(1'b0, 18'h300 + 18'(i * 8), '0, '0);
        drain();

        // Read issued in RACK, reset in its third cycle
        issue(1'b0, 18'h00100, '0, '0);
        issue(1'b0, 18'h00200, '0, '0);
        repeat (2) @(negedge clk);
        chk("pre_abort_ce", 64'(ce_n), 64'd0);
        rst = 1'b1;
        #1;
        chk_reset_pins("abort");
        chk("abort_pending", 64'(q.size()), 64'd1);
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_abort_ce", 64'(ce_n), 64'd1);
        issue(1'b0, 18'h00100, '0, '0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
